// File: rtl/dcache_controller.sv
`timescale 1ns / 1ps
// ----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back data cache between the CPU load/store path and a
// 32-bit-block data memory. 8 lines x 4 bytes, 8-bit byte address split as
// tag[7:5] / index[4:2] / offset[1:0]. Hits complete with no stall. A miss
// stalls the CPU, writes back the victim line if it is dirty, fetches the
// new block and then re-evaluates the access as a hit.
//
// Optional feature macro: DCACHE_STATS_EN adds 16-bit hit/miss counters.
//
// Ports
//   CLK            in   1   rising-edge clock
//   RESET          in   1   synchronous, active-high reset
//   READ           in   1   CPU byte read request
//   WRITE          in   1   CPU byte write request (wins over READ)
//   ADDRESS        in   8   CPU byte address
//   WRITEDATA      in   8   CPU store data
//   READDATA       out  8   load data, valid while READ=1 and BUSYWAIT=0
//   BUSYWAIT       out  1   CPU stall
//   MEM_READ       out  1   block fetch request
//   MEM_WRITE      out  1   block write-back request
//   MEM_ADDRESS    out  6   block address {tag, index}
//   MEM_WRITEDATA  out  32  write-back block, byte 0 in bits [7:0]
//   MEM_READDATA   in   32  fetched block
//   MEM_BUSYWAIT   in   1   memory busy
//   HIT_COUNT      out  16  (DCACHE_STATS_EN only) hits completed in IDLE
//   MISS_COUNT     out  16  (DCACHE_STATS_EN only) misses started
// ----------------------------------------------------------------------------
module dcache_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Line storage
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  // Address fields; the CPU holds ADDRESS stable during a stall, so these
  // are used directly rather than latched.
  logic [2:0] addr_tag;
  logic [2:0] addr_idx;
  logic [1:0] addr_off;
  logic [4:0] byte_lsb;

  assign addr_tag = ADDRESS[7:5];
  assign addr_idx = ADDRESS[4:2];
  assign addr_off = ADDRESS[1:0];
  assign byte_lsb = {addr_off, 3'b000};

  logic req;
  logic hit;
  logic hit_wr_en;
  logic fill_en;

  assign req = READ | WRITE;
  assign hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned and infers a latch.
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0000_0000;
    READDATA      = 8'h00;
    hit_wr_en     = 1'b0;
    fill_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A combined READ+WRITE is a write; READDATA still shows the
            // addressed byte as it was before this edge.
            if (READ) begin
              READDATA = data_q[addr_idx][byte_lsb +: 8];
            end
            hit_wr_en = WRITE;
          end else begin
            BUSYWAIT = 1'b1;
            if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end

      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
        MEM_WRITEDATA = data_q[addr_idx];
        if (!MEM_BUSYWAIT) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Valid / dirty bits: cleared by reset, which also makes any aborted fill
  // invisible since the line is left invalid.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else if (fill_en) begin
      valid_q[addr_idx] <= 1'b1;
      dirty_q[addr_idx] <= 1'b0;
    end else if (hit_wr_en) begin
      dirty_q[addr_idx] <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Tag and data arrays
  // --------------------------------------------------------------------------
  // NOTE: the tag/data arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, so clearing them would only cost
  // reset fan-out.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_en) begin
        tag_q[addr_idx]  <= addr_tag;
        data_q[addr_idx] <= MEM_READDATA;
      end else if (hit_wr_en) begin
        data_q[addr_idx][byte_lsb +: 8] <= WRITEDATA;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics counters (wrap naturally at 16 bits)
  // --------------------------------------------------------------------------
  logic        hit_event;
  logic        miss_event;
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  // A hit counts only when it completes in IDLE; the re-evaluate cycle after
  // a fill therefore counts as a hit as well as the original miss.
  assign hit_event  = (state_q == IDLE) && req && hit;
  assign miss_event = (state_q == IDLE) && req && !hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (hit_event) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
      if (miss_event) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule
